// File: rtl/pcw_loader_pkg.sv
// Shared types and helpers for the multi-segment boot image loader.
package pcw_loader_pkg;

   typedef enum logic [3:0] {
      IDLE,
      SEG,
      WSET,
      WEND,
      RD,
      CHK,
      EXEC,
      FIN,
      DONE,
      ERROR
   } state_e;

   // Widest flattened segment vector and widest single field the slicer handles.
   localparam int unsigned FLAT_W  = 256;
   localparam int unsigned FIELD_W = 32;

   // Extract field idx of width w from a flattened per-segment vector.
   function automatic logic [FIELD_W-1:0] seg_field(input logic [FLAT_W-1:0] flat,
                                                    input int unsigned       idx,
                                                    input int unsigned       w);
      logic [FLAT_W-1:0]  sh;
      logic [FIELD_W-1:0] mask;
      sh   = flat >> (idx * w);
      mask = (w >= FIELD_W) ? '1 : FIELD_W'((64'd1 << w) - 64'd1);
      return sh[FIELD_W-1:0] & mask;
   endfunction

endpackage

// File: rtl/pcw_ref_tick.sv
// Registered one-clk tick on each rising edge of the SDRAM phase reference.
module pcw_ref_tick (
   input  logic clk,
   input  logic reset_n,
   input  logic sdram_clk_ref,
   input  logic sdram_ready,
   output logic tick
);

   logic ref_q;

   // Edge detect against the previous sample; gated by SDRAM readiness.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ref_q <= 1'b0;
         tick  <= 1'b0;
      end else begin
         ref_q <= sdram_clk_ref;
         tick  <= sdram_ready & sdram_clk_ref & ~ref_q;
      end
   end

endmodule

// File: rtl/pcw_image_loader.sv
// Copies ROM segments into SDRAM, optionally verifies, then launches execution.
module pcw_image_loader
   import pcw_loader_pkg::*;
#(
   parameter int unsigned ADDR_W    = 16,
   parameter int unsigned DATA_W    = 8,
   parameter int unsigned ROM_AW    = 12,
   parameter int unsigned SEG_COUNT = 2,
   parameter int unsigned LEN_W     = 16,
   parameter int unsigned VERIFY    = 0
) (
   input  logic                        clk,
   input  logic                        reset_n,
   input  logic                        start,
   input  logic                        sdram_clk_ref,
   input  logic                        sdram_ready,
   input  logic [SEG_COUNT*ROM_AW-1:0] seg_src,
   input  logic [SEG_COUNT*ADDR_W-1:0] seg_dst,
   input  logic [SEG_COUNT*LEN_W-1:0]  seg_len,
   input  logic [ADDR_W-1:0]           entry_addr,
   output logic [ROM_AW-1:0]           rom_addr,
   input  logic [DATA_W-1:0]           rom_data,
   input  logic [DATA_W-1:0]           rd_data,
   output logic                        wr,
   output logic                        rd,
   output logic [ADDR_W-1:0]           addr,
   output logic [DATA_W-1:0]           data,
   output logic [ADDR_W-1:0]           exec_addr,
   output logic                        exec_enable,
   output logic                        active,
   output logic                        done,
   output logic                        error,
   output logic [ADDR_W-1:0]           err_addr
);

   localparam int unsigned IDX_W = (SEG_COUNT > 1) ? $clog2(SEG_COUNT) : 1;

   state_e             state_q, state_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [LEN_W-1:0]   remaining_q, remaining_d;
   logic [ROM_AW-1:0]  rom_addr_d;
   logic [ADDR_W-1:0]  addr_d, exec_addr_d, err_addr_d;
   logic [DATA_W-1:0]  data_d;
   logic               wr_d, rd_d, exec_enable_d, active_d, done_d, error_d;

   logic               tick, tick_en, last_seg, mismatch, last_word;
   logic [ROM_AW-1:0]  cur_src;
   logic [ADDR_W-1:0]  cur_dst;
   logic [LEN_W-1:0]   cur_len;
   state_e             adv_state;

   pcw_ref_tick u_tick (
      .clk           (clk),
      .reset_n       (reset_n),
      .sdram_clk_ref (sdram_clk_ref),
      .sdram_ready   (sdram_ready),
      .tick          (tick)
   );

   // Re-gate with live readiness so a drop freezes the FSM on the very next clk.
   assign tick_en   = tick & sdram_ready;
   assign cur_src   = ROM_AW'(seg_field(FLAT_W'(seg_src), 32'(idx_q), ROM_AW));
   assign cur_dst   = ADDR_W'(seg_field(FLAT_W'(seg_dst), 32'(idx_q), ADDR_W));
   assign cur_len   = LEN_W'(seg_field(FLAT_W'(seg_len), 32'(idx_q), LEN_W));
   assign last_seg  = (idx_q == IDX_W'(SEG_COUNT - 1));
   assign mismatch  = (rd_data != data);
   assign last_word = (remaining_q == LEN_W'(1));
   assign adv_state = last_word ? (last_seg ? EXEC : SEG) : WSET;

   // State and datapath registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         idx_q       <= '0;
         remaining_q <= '0;
         rom_addr    <= '0;
         addr        <= '0;
         data        <= '0;
         wr          <= 1'b0;
         rd          <= 1'b0;
         exec_addr   <= '0;
         exec_enable <= 1'b0;
         active      <= 1'b0;
         done        <= 1'b0;
         error       <= 1'b0;
         err_addr    <= '0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         remaining_q <= remaining_d;
         rom_addr    <= rom_addr_d;
         addr        <= addr_d;
         data        <= data_d;
         wr          <= wr_d;
         rd          <= rd_d;
         exec_addr   <= exec_addr_d;
         exec_enable <= exec_enable_d;
         active      <= active_d;
         done        <= done_d;
         error       <= error_d;
         err_addr    <= err_addr_d;
      end
   end

   // Next state: only start leaves the rest states without a tick.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE, DONE, ERROR: if (start) state_d = SEG;
         SEG:  if (tick_en) state_d = (cur_len == '0) ? (last_seg ? EXEC : SEG) : WSET;
         WSET: if (tick_en) state_d = WEND;
         WEND: if (tick_en) state_d = (VERIFY != 0) ? RD : adv_state;
         RD:   if (tick_en) state_d = CHK;
         CHK:  if (tick_en) state_d = mismatch ? ERROR : adv_state;
         EXEC: if (tick_en) state_d = FIN;
         FIN:  if (tick_en) state_d = DONE;
         default: state_d = IDLE;
      endcase
   end

   // Register updates; word advance is folded into the WEND/CHK exit tick.
   always_comb begin
      logic adv;
      adv           = 1'b0;
      idx_d         = idx_q;
      remaining_d   = remaining_q;
      rom_addr_d    = rom_addr;
      addr_d        = addr;
      data_d        = data;
      wr_d          = wr;
      rd_d          = rd;
      exec_addr_d   = exec_addr;
      exec_enable_d = exec_enable;
      active_d      = active;
      done_d        = done;
      error_d       = error;
      err_addr_d    = err_addr;
      case (state_q)
         IDLE, DONE, ERROR: begin
            if (start) begin
               exec_addr_d = entry_addr;
               done_d      = 1'b0;
               error_d     = 1'b0;
               err_addr_d  = '0;
               active_d    = 1'b1;
               idx_d       = '0;
            end
         end
         SEG: begin
            if (tick_en) begin
               if (cur_len == '0) begin
                  if (!last_seg) idx_d = idx_q + IDX_W'(1);
               end else begin
                  addr_d      = cur_dst;
                  rom_addr_d  = cur_src;
                  remaining_d = cur_len;
               end
            end
         end
         WSET: begin
            if (tick_en) begin
               data_d = rom_data;
               wr_d   = 1'b1;
            end
         end
         WEND: begin
            if (tick_en) begin
               wr_d = 1'b0;
               if (VERIFY != 0) rd_d = 1'b1;
               else adv = 1'b1;
            end
         end
         RD: if (tick_en) rd_d = 1'b0;
         CHK: begin
            if (tick_en) begin
               if (mismatch) begin
                  error_d    = 1'b1;
                  err_addr_d = addr;
                  active_d   = 1'b0;
               end else begin
                  adv = 1'b1;
               end
            end
         end
         EXEC: if (tick_en) exec_enable_d = 1'b1;
         FIN: begin
            if (tick_en) begin
               exec_enable_d = 1'b0;
               active_d      = 1'b0;
               done_d        = 1'b1;
            end
         end
         default: ;
      endcase
      if (adv) begin
         addr_d      = addr + ADDR_W'(1);
         rom_addr_d  = rom_addr + ROM_AW'(1);
         remaining_d = remaining_q - LEN_W'(1);
         if (last_word && !last_seg) idx_d = idx_q + IDX_W'(1);
      end
   end

endmodule

// File: tb/tb_pcw_image_loader.sv
// Scoreboard bench: one plain-copy loader instance and one verifying instance.
module tb_pcw_image_loader;

   typedef struct {
      logic [15:0] addr;
      logic [7:0]  data;
      int          gap;
   } wr_t;

   logic        clk = 1'b0, reset_n = 1'b0, sdram_clk_ref = 1'b0, sdram_ready = 1'b1;
   logic        start_nv = 1'b0, start_v = 1'b0;
   logic [23:0] seg_src = '0;
   logic [31:0] seg_dst = '0;
   logic [31:0] seg_len = '0;
   logic [15:0] entry_addr = '0;

   logic [11:0] rom_addr_nv, rom_addr_v;
   logic [7:0]  rom_data_nv = '0, rom_data_v = '0;
   logic [7:0]  rd_data_nv, rd_data_v, data_nv, data_v;
   logic        wr_nv, rd_nv, exec_enable_nv, active_nv, done_nv, error_nv;
   logic        wr_v, rd_v, exec_enable_v, active_v, done_v, error_v;
   logic [15:0] addr_nv, exec_addr_nv, err_addr_nv, addr_v, exec_addr_v, err_addr_v;

   logic [7:0]  rom [4096];
   logic [7:0]  mem_v [65536];
   logic        corrupt_en = 1'b0;
   logic [15:0] corrupt_a = '0;

   wr_t         q_nv[$], q_v[$];
   logic [15:0] q_rd[$];

   int n_checks = 0, n_fail = 0, cyc = 0;
   int last_wr_nv = 0, last_wr_v = 0, exec_cnt_nv = 0, exec_cnt_v = 0;
   int exec_start_nv = 0, exec_start_v = 0;
   logic wr_nv_q = 1'b0, rd_nv_q = 1'b0, ex_nv_q = 1'b0;
   logic wr_v_q = 1'b0, rd_v_q = 1'b0, ex_v_q = 1'b0;

   always #5 clk = ~clk;
   always #30 sdram_clk_ref = ~sdram_clk_ref;
   always @(posedge clk) cyc <= cyc + 1;

   // Synchronous ROM, one clk latency.
   always @(posedge clk) begin
      rom_data_nv <= rom[rom_addr_nv];
      rom_data_v  <= rom[rom_addr_v];
   end

   assign rd_data_nv = 8'h00;
   assign rd_data_v  = mem_v[addr_v] ^ ((corrupt_en && addr_v == corrupt_a) ? 8'hFF : 8'h00);

   pcw_image_loader #(.ADDR_W(16), .DATA_W(8), .ROM_AW(12), .SEG_COUNT(2), .LEN_W(16), .VERIFY(0)) u_nv (
      .clk(clk), .reset_n(reset_n), .start(start_nv), .sdram_clk_ref(sdram_clk_ref),
      .sdram_ready(sdram_ready), .seg_src(seg_src), .seg_dst(seg_dst), .seg_len(seg_len),
      .entry_addr(entry_addr), .rom_addr(rom_addr_nv), .rom_data(rom_data_nv), .rd_data(rd_data_nv),
      .wr(wr_nv), .rd(rd_nv), .addr(addr_nv), .data(data_nv), .exec_addr(exec_addr_nv),
      .exec_enable(exec_enable_nv), .active(active_nv), .done(done_nv), .error(error_nv),
      .err_addr(err_addr_nv));

   pcw_image_loader #(.ADDR_W(16), .DATA_W(8), .ROM_AW(12), .SEG_COUNT(2), .LEN_W(16), .VERIFY(1)) u_v (
      .clk(clk), .reset_n(reset_n), .start(start_v), .sdram_clk_ref(sdram_clk_ref),
      .sdram_ready(sdram_ready), .seg_src(seg_src), .seg_dst(seg_dst), .seg_len(seg_len),
      .entry_addr(entry_addr), .rom_addr(rom_addr_v), .rom_data(rom_data_v), .rd_data(rd_data_v),
      .wr(wr_v), .rd(rd_v), .addr(addr_v), .data(data_v), .exec_addr(exec_addr_v),
      .exec_enable(exec_enable_v), .active(active_v), .done(done_v), .error(error_v),
      .err_addr(err_addr_v));

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Copy-only instance monitor.
   always @(negedge clk) begin
      wr_t it;
      if (wr_nv && !wr_nv_q) begin
         if (q_nv.size() == 0) check_eq("nv_unexpected_wr", {16'h0, addr_nv}, 32'hFFFF_FFFF);
         else begin
            it = q_nv.pop_front();
            check_eq("nv_wr_addr", addr_nv, it.addr);
            check_eq("nv_wr_data", data_nv, it.data);
            if (it.gap != 0) check_eq("nv_wr_gap", cyc - last_wr_nv, it.gap);
         end
         last_wr_nv <= cyc;
      end
      if (rd_nv && !rd_nv_q) check_eq("nv_unexpected_rd", 1, 0);
      if (exec_enable_nv && !ex_nv_q) begin
         exec_cnt_nv++;
         exec_start_nv <= cyc;
      end
      if (!exec_enable_nv && ex_nv_q) check_eq("nv_exec_width", cyc - exec_start_nv, 6);
      wr_nv_q <= wr_nv;
      rd_nv_q <= rd_nv;
      ex_nv_q <= exec_enable_nv;
   end

   // Verifying instance monitor; also acts as the SDRAM memory model.
   always @(negedge clk) begin
      wr_t it;
      if (wr_v && !wr_v_q) begin
         mem_v[addr_v] = data_v;
         check_eq("v_wr_excl", rd_v, 0);
         if (q_v.size() == 0) check_eq("v_unexpected_wr", {16'h0, addr_v}, 32'hFFFF_FFFF);
         else begin
            it = q_v.pop_front();
            check_eq("v_wr_addr", addr_v, it.addr);
            check_eq("v_wr_data", data_v, it.data);
            if (it.gap != 0) check_eq("v_wr_gap", cyc - last_wr_v, it.gap);
         end
         last_wr_v <= cyc;
      end
      if (rd_v && !rd_v_q) begin
         check_eq("v_rd_excl", wr_v, 0);
         if (q_rd.size() == 0) check_eq("v_unexpected_rd", {16'h0, addr_v}, 32'hFFFF_FFFF);
         else check_eq("v_rd_addr", addr_v, q_rd.pop_front());
      end
      if (exec_enable_v && !ex_v_q) begin
         exec_cnt_v++;
         exec_start_v <= cyc;
      end
      if (!exec_enable_v && ex_v_q) check_eq("v_exec_width", cyc - exec_start_v, 6);
      wr_v_q <= wr_v;
      rd_v_q <= rd_v;
      ex_v_q <= exec_enable_v;
   end

   task automatic set_cfg(input logic [11:0] s0, input logic [15:0] d0, input logic [15:0] l0,
                          input logic [11:0] s1, input logic [15:0] d1, input logic [15:0] l1);
      seg_src = {s1, s0};
      seg_dst = {d1, d0};
      seg_len = {l1, l0};
   endtask

   task automatic push_seg(input bit v, input logic [11:0] src, input logic [15:0] dst,
                           input int len, input int gap, input int first_gap);
      for (int i = 0; i < len; i++) begin
         wr_t it;
         it.addr = dst + 16'(i);
         it.data = rom[src + 12'(i)];
         it.gap  = (i == 0) ? first_gap : gap;
         if (v) begin
            q_v.push_back(it);
            q_rd.push_back(it.addr);
         end else begin
            q_nv.push_back(it);
         end
      end
   endtask

   task automatic pulse_start(input bit v);
      @(negedge clk);
      if (v) start_v = 1'b1;
      else start_nv = 1'b1;
      @(negedge clk);
      start_v  = 1'b0;
      start_nv = 1'b0;
   endtask

   task automatic wait_end(input bit v, input int max_clk, input string tag);
      int n;
      n = 0;
      while (!(v ? (done_v | error_v) : (done_nv | error_nv)) && n < max_clk) begin
         @(negedge clk);
         n++;
      end
      check_eq({tag, "_timeout"}, 32'(n < max_clk), 1);
      repeat (2) @(negedge clk);
   endtask

   task automatic wait_q_nv(input int left, input int max_clk, input string tag);
      int n;
      n = 0;
      while (q_nv.size() > left && n < max_clk) begin
         @(negedge clk);
         n++;
      end
      check_eq({tag, "_timeout"}, 32'(n < max_clk), 1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] snap;
      int          ex0;
      for (int i = 0; i < 4096; i++) rom[i] = 8'((i * 37 + 11) & 255);
      rom[0] = 8'hAA; rom[1] = 8'hBB; rom[2] = 8'hCC; rom[3] = 8'hDD;

      // Reset values.
      #2;
      check_eq("rst_nv_flags", {wr_nv, rd_nv, exec_enable_nv, active_nv, done_nv, error_nv}, 0);
      check_eq("rst_nv_addr", {addr_nv, exec_addr_nv}, 0);
      check_eq("rst_nv_misc", {err_addr_nv, rom_addr_nv, data_nv}, 0);
      check_eq("rst_v_flags", {wr_v, rd_v, exec_enable_v, active_v, done_v, error_v}, 0);
      #21 reset_n = 1'b1;
      repeat (10) @(negedge clk);

      // T1: single segment, second segment empty.
      set_cfg(12'h000, 16'h0000, 16'd4, 12'h000, 16'h0000, 16'd0);
      entry_addr = 16'h0100;
      push_seg(0, 12'h000, 16'h0000, 4, 12, 0);
      pulse_start(0);
      check_eq("t1_active", {active_nv, done_nv}, 2'b10);
      wait_end(0, 600, "t1");
      check_eq("t1_q_empty", q_nv.size(), 0);
      check_eq("t1_flags", {done_nv, active_nv, error_nv}, 3'b100);
      check_eq("t1_exec_addr", exec_addr_nv, 16'h0100);
      check_eq("t1_exec_cnt", exec_cnt_nv, 1);
      check_eq("t1_exec_lat", exec_start_nv - last_wr_nv, 18);

      // T2 + ignored start while active.
      set_cfg(12'h000, 16'h0000, 16'd2, 12'h010, 16'hF000, 16'd3);
      entry_addr = 16'h0234;
      push_seg(0, 12'h000, 16'h0000, 2, 12, 0);
      push_seg(0, 12'h010, 16'hF000, 3, 12, 18);
      pulse_start(0);
      repeat (30) @(negedge clk);
      entry_addr = 16'h9999;
      pulse_start(0);
      check_eq("t6_ignored_exec_addr", exec_addr_nv, 16'h0234);
      check_eq("t6_ignored_active", active_nv, 1);
      entry_addr = 16'h0234;
      wait_end(0, 900, "t2");
      check_eq("t2_q_empty", q_nv.size(), 0);
      check_eq("t2_flags", {done_nv, active_nv, error_nv}, 3'b100);
      check_eq("t2_exec_addr", exec_addr_nv, 16'h0234);
      check_eq("t2_exec_cnt", exec_cnt_nv, 2);
      check_eq("t2_exec_lat", exec_start_nv - last_wr_nv, 12);

      // T6: rerun from DONE, identical sequence.
      push_seg(0, 12'h000, 16'h0000, 2, 12, 0);
      push_seg(0, 12'h010, 16'hF000, 3, 12, 18);
      pulse_start(0);
      check_eq("t6_done_cleared", {done_nv, active_nv}, 2'b01);
      wait_end(0, 900, "t6");
      check_eq("t6_q_empty", q_nv.size(), 0);
      check_eq("t6_flags", {done_nv, active_nv, error_nv}, 3'b100);
      check_eq("t6_exec_cnt", exec_cnt_nv, 3);

      // T4: sdram_ready low for 20 ticks mid-segment.
      set_cfg(12'h020, 16'h0300, 16'd6, 12'h000, 16'h0000, 16'd0);
      entry_addr = 16'h0400;
      push_seg(0, 12'h020, 16'h0300, 6, 0, 0);
      pulse_start(0);
      wait_q_nv(4, 300, "t4_two_words");
      repeat (3) @(negedge clk);
      sdram_ready = 1'b0;
      repeat (2) @(negedge clk);
      snap = {6'h0, wr_nv, rd_nv, addr_nv, data_nv};
      ex0 = 32'(rom_addr_nv);
      repeat (120) @(negedge clk);
      check_eq("t4_frozen_bus", {6'h0, wr_nv, rd_nv, addr_nv, data_nv}, snap);
      check_eq("t4_frozen_rom", 32'(rom_addr_nv), ex0);
      check_eq("t4_frozen_active", active_nv, 1);
      sdram_ready = 1'b1;
      wait_end(0, 900, "t4");
      check_eq("t4_q_empty", q_nv.size(), 0);
      check_eq("t4_flags", {done_nv, active_nv, error_nv}, 3'b100);
      check_eq("t4_exec_cnt", exec_cnt_nv, 4);

      // T5: async reset during WEND of word 5, then restart.
      set_cfg(12'h040, 16'h0500, 16'd8, 12'h000, 16'h0000, 16'd0);
      entry_addr = 16'h0600;
      push_seg(0, 12'h040, 16'h0500, 5, 12, 0);
      pulse_start(0);
      wait_q_nv(0, 600, "t5_five_words");
      #13 reset_n = 1'b0;
      #1;
      check_eq("t5_rst_flags", {wr_nv, rd_nv, exec_enable_nv, active_nv, done_nv, error_nv}, 0);
      check_eq("t5_rst_addr", {addr_nv, exec_addr_nv}, 0);
      check_eq("t5_rst_misc", {err_addr_nv, rom_addr_nv, data_nv}, 0);
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      repeat (40) @(negedge clk);
      check_eq("t5_idle_after_rst", {active_nv, wr_nv}, 0);
      push_seg(0, 12'h040, 16'h0500, 8, 12, 0);
      pulse_start(0);
      wait_end(0, 900, "t5");
      check_eq("t5_q_empty", q_nv.size(), 0);
      check_eq("t5_flags", {done_nv, active_nv, error_nv}, 3'b100);
      check_eq("t5_exec_addr", exec_addr_nv, 16'h0600);

      // T3a: verify instance, clean run.
      set_cfg(12'h000, 16'h0000, 16'd4, 12'h000, 16'h0000, 16'd0);
      entry_addr = 16'h0700;
      push_seg(1, 12'h000, 16'h0000, 4, 24, 0);
      pulse_start(1);
      wait_end(1, 900, "t3a");
      check_eq("t3a_q_empty", q_v.size() + q_rd.size(), 0);
      check_eq("t3a_flags", {done_v, active_v, error_v}, 3'b100);
      check_eq("t3a_exec", {exec_cnt_v[15:0], exec_addr_v}, {16'd1, 16'h0700});

      // T3b: corrupted read-back at 0x0002.
      corrupt_a  = 16'h0002;
      corrupt_en = 1'b1;
      push_seg(1, 12'h000, 16'h0000, 3, 24, 0);
      pulse_start(1);
      check_eq("t3b_cleared", {done_v, error_v, active_v}, 3'b001);
      wait_end(1, 900, "t3b");
      repeat (60) @(negedge clk);
      check_eq("t3b_q_empty", q_v.size() + q_rd.size(), 0);
      check_eq("t3b_flags", {done_v, active_v, error_v}, 3'b001);
      check_eq("t3b_err_addr", err_addr_v, 16'h0002);
      check_eq("t3b_no_exec", exec_cnt_v, 1);

      // T3c: restart from ERROR clears it and completes.
      corrupt_en = 1'b0;
      push_seg(1, 12'h000, 16'h0000, 4, 24, 0);
      pulse_start(1);
      check_eq("t3c_cleared", {error_v, err_addr_v}, 0);
      wait_end(1, 900, "t3c");
      check_eq("t3c_flags", {done_v, active_v, error_v}, 3'b100);
      check_eq("t3c_exec_cnt", exec_cnt_v, 2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/pcw_image_loader.md
Name: pcw_image_loader

Overview:
- Parametrised successor to the single-image boot starter.
- Copies up to SEG_COUNT ROM segments into SDRAM, each with its own source offset, destination address and length.
- Optionally reads back and verifies every written word. Then pulses exec_enable with a latched entry address.
- Sits between the boot ROM, the SDRAM arbiter port and the Z80 reset/exec logic.

Parameters:
ADDR_W, 16, SDRAM/CPU address width
DATA_W, 8, data word width
ROM_AW, 12, boot ROM address width
SEG_COUNT, 2, number of segments (1..8)
LEN_W, 16, segment length counter width
VERIFY, 0, 1 = read back and compare each word after writing

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
start  in  1  one-clk pulse; begins a load sequence
sdram_clk_ref  in  1  SDRAM phase reference; a rising edge paces all accesses
sdram_ready  in  1  SDRAM initialised; ticks are gated by it
seg_src  in  SEG_COUNT*ROM_AW  per-segment ROM start offset (segment i at [i*ROM_AW +: ROM_AW])
seg_dst  in  SEG_COUNT*ADDR_W  per-segment SDRAM destination
seg_len  in  SEG_COUNT*LEN_W  per-segment word count (0 = skip)
entry_addr  in  ADDR_W  execution address, latched on start
rom_addr  out  ROM_AW  boot ROM address
rom_data  in  DATA_W  boot ROM data, valid 1 clk after rom_addr
rd_data  in  DATA_W  SDRAM read data, valid at the tick after rd deasserts
wr  out  1  SDRAM write strobe
rd  out  1  SDRAM read strobe
addr  out  ADDR_W  SDRAM address
data  out  DATA_W  SDRAM write data
exec_addr  out  ADDR_W  execution address
exec_enable  out  1  high for exactly one tick period after the final segment
active  out  1  high from start until DONE or ERROR
done  out  1  sticky; set on successful completion, cleared by start
error  out  1  sticky; verify mismatch, cleared by start
err_addr  out  ADDR_W  SDRAM address of the first mismatch

Behaviour:
- Reset (reset_n low, async): all outputs 0; state IDLE; segment index 0. Reset mid-copy aborts with no further strobes.
- Tick: sdram_ready & sdram_clk_ref rising, detected against a registered copy of sdram_clk_ref. All state transitions except IDLE->SEG occur only on a tick.
- Ticks are at least 4 clk apart. The ROM latency is therefore hidden.
- When sdram_ready is low, the FSM freezes and all outputs hold.
- start is accepted only in IDLE, DONE or ERROR. It is ignored while active.
  - On acceptance: latch entry_addr into exec_addr; clear done, error and err_addr; set active; seg index 0; go to SEG.
- SEG (tick):
  - If seg_len[idx] == 0: advance idx (or go to EXEC after the last segment).
  - Otherwise: load addr = seg_dst, rom_addr = seg_src, remaining = seg_len; go to WSET.
- WSET (tick): data <= rom_data; wr <= 1; go to WEND.
- WEND (tick): wr <= 0.
  - If VERIFY: rd <= 1; go to RD.
  - Else: go to ADV.
- RD (tick): rd <= 0; go to CHK.
- CHK (tick):
  - If rd_data != data: error <= 1, err_addr <= addr, active <= 0; go to ERROR.
  - Else: go to ADV.
- ADV (same tick as WEND/CHK exit; ADV is combinational): addr+1, rom_addr+1, remaining-1.
  - If remaining was 1: next segment via SEG, or EXEC after the last.
  - Else: WSET.
- Throughput: 2 ticks/word without verify, 4 ticks/word with verify.
- EXEC (tick): exec_enable <= 1; go to FIN.
- FIN (tick): exec_enable <= 0; active <= 0; done <= 1; go to DONE.
- Address arithmetic: addr and rom_addr wrap modulo 2^ADDR_W and 2^ROM_AW. No overlap checking is done.
- ERROR: exec_enable is never asserted.
- All segments length 0: SEG x SEG_COUNT, then EXEC, so exec still fires.
- Only one of wr and rd is ever high at a time.

Decomposition:
- Package pcw_loader_pkg holds:
  - the state enum (IDLE, SEG, WSET, WEND, RD, CHK, EXEC, FIN, DONE, ERROR);
  - a function to slice flattened segment fields.
- Sub-module pcw_ref_tick (clk, reset_n, sdram_clk_ref, sdram_ready -> tick), reused by other SDRAM-paced blocks.

Test Plan:
1. VERIFY=0, seg0 src=0 dst=0x0000 len=4, seg1 len=0, ROM=AA,BB,CC,DD, start -> wr pulses at addr 0..3 with data AA..DD, 2 ticks apart. Then exec_enable for 1 tick with exec_addr=entry_addr=0x0100; done=1, active=0.
2. Two segments: seg0 src=0 dst=0x0000 len=2, seg1 src=0x10 dst=0xF000 len=3 -> writes at 0,1 then F000..F002 from ROM 0x10..0x12. Total 10 write ticks before EXEC.
3. VERIFY=1, bench memory model corrupts addr 0x0002 -> write/read at 0,1,2. Then error=1, err_addr=0x0002, no exec_enable, no access at 0x0003.
4. Hold sdram_ready low for 20 ticks mid-segment -> wr/rd/addr frozen, no lost or duplicated word. The copy resumes correctly.
5. Assert reset_n low during WEND of word 5 -> all outputs 0 immediately (async). A subsequent start reloads from the segment beginning.
6. Pulse start while active; afterwards start from DONE -> the first is ignored. The second clears done and reruns the full sequence identically.
